// File: rtl/nios_numbers_out_pkg.sv
// Shared definitions for the Nios output mailbox: register map, STATUS bit
// positions, handshake state encoding and timer sizing helper.
package nios_numbers_out_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_OVERFLOW = 1;
    localparam int STAT_TIMEOUT  = 2;
    localparam int STAT_DONE     = 3;

    typedef enum logic {
        S_IDLE,
        S_PRESENT
    } state_e;

    // Counter only needs to reach ACK_TIMEOUT-1; keep at least one bit.
    function automatic int timer_width(input int ack_timeout);
        return (ack_timeout < 2) ? 1 : $clog2(ack_timeout);
    endfunction

endpackage

// File: rtl/nios_numbers_out_timer.sv
// Saturating ack-timeout counter: cleared on each new value, counts while a
// value is presented, flags expiry on the last allowed cycle.
module nios_numbers_out_timer
    import nios_numbers_out_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int TW = timer_width(ACK_TIMEOUT);
    localparam logic [TW-1:0] LAST = (ACK_TIMEOUT == 0) ? '0 : TW'(ACK_TIMEOUT - 1);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    always_comb begin
        timer_d = timer_q;
        if (clear) begin
            timer_d = '0;
        end else if (enable && (timer_q != '1)) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    // A zero timeout means wait forever.
    assign expire = (ACK_TIMEOUT != 0) && enable && (timer_q == LAST);

endmodule

// File: rtl/nios_numbers_out.sv
// Avalon-MM output mailbox: Nios writes DATA, fabric consumes it via valid/ack.
// Optional CONTROL register and irq output with NIOS_NUMBERS_OUT_IRQ_EN.
module nios_numbers_out
    import nios_numbers_out_pkg::*;
#(
    parameter int          DATA_WIDTH  = 16,
    parameter logic [31:0] RESET_VALUE = 32'd0,
    parameter int          ACK_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ack
`ifdef NIOS_NUMBERS_OUT_IRQ_EN
    ,
    output logic                  irq
`endif
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  overflow_q, overflow_d;
    logic                  timeout_q, timeout_d;
    logic [31:0]           readdata_q, readdata_d;

    logic wr, wr_data, wr_status, wr_control;
    logic load, drop, ack_done, expire, timeout_hit;
    logic done_bit, mask_bit;
    logic unused_wdata;

    assign wr         = chipselect & ~write_n;
    assign wr_data    = wr && (address == ADDR_DATA);
    assign wr_status  = wr && (address == ADDR_STATUS);
    assign wr_control = wr && (address == ADDR_CONTROL);
    assign unused_wdata = ^{writedata, wr_control};

    // A write while a value is pending is only taken if the consumer acks now.
    assign load        = wr_data && ((state_q == S_IDLE) || out_ack);
    assign drop        = wr_data && (state_q == S_PRESENT) && !out_ack;
    assign ack_done    = (state_q == S_PRESENT) && out_ack;
    assign timeout_hit = (state_q == S_PRESENT) && !out_ack && expire;

    nios_numbers_out_timer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (load),
        .enable (state_q == S_PRESENT),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (wr_data) state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (out_ack) begin
                    state_d = wr_data ? S_PRESENT : S_IDLE;
                end else if (expire) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == S_PRESENT);
        out_data  = data_q;
        readdata  = readdata_q;
    end

    // Sticky flags: a set in the same cycle as a write-1-to-clear wins.
    always_comb begin
        data_d     = load ? writedata[DATA_WIDTH-1:0] : data_q;
        overflow_d = drop | (overflow_q & ~(wr_status & writedata[STAT_OVERFLOW]));
        timeout_d  = timeout_hit | (timeout_q & ~(wr_status & writedata[STAT_TIMEOUT]));
        case (address)
            ADDR_DATA:    readdata_d = 32'(data_q);
            ADDR_STATUS:  readdata_d = {28'd0, done_bit, timeout_q, overflow_q,
                                        state_q == S_PRESENT};
            ADDR_CONTROL: readdata_d = {31'd0, mask_bit};
            default:      readdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= RESET_VALUE[DATA_WIDTH-1:0];
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            readdata_q <= 32'd0;
        end else begin
            data_q     <= data_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
            readdata_q <= readdata_d;
        end
    end

`ifdef NIOS_NUMBERS_OUT_IRQ_EN
    logic done_pend_q, done_pend_d;
    logic irq_mask_q, irq_mask_d;
    logic irq_q, irq_d;

    always_comb begin
        done_pend_d = ack_done | (done_pend_q & ~(wr_status & writedata[STAT_DONE]));
        irq_mask_d  = wr_control ? writedata[0] : irq_mask_q;
        irq_d       = irq_mask_d & (done_pend_d | overflow_d | timeout_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_pend_q <= 1'b0;
            irq_mask_q  <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            done_pend_q <= done_pend_d;
            irq_mask_q  <= irq_mask_d;
            irq_q       <= irq_d;
        end
    end

    assign done_bit = done_pend_q;
    assign mask_bit = irq_mask_q;
    assign irq      = irq_q;
`else
    assign done_bit = 1'b0;
    assign mask_bit = 1'b0;
`endif

endmodule

// File: tb/tb_nios_numbers_out.sv
// Directed bench for nios_numbers_out; completed transfers are checked
// against a scoreboard of values written by the stimulus.
module tb_nios_numbers_out;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ack;
`ifdef NIOS_NUMBERS_OUT_IRQ_EN
    logic        irq;
    localparam logic [31:0] DN = 32'h8;
    localparam logic [31:0] CTRL_RB = 32'h1;
`else
    localparam logic [31:0] DN = 32'h0;
    localparam logic [31:0] CTRL_RB = 32'h0;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] sb[$];

    always #5 clk = ~clk;

    nios_numbers_out #(
        .DATA_WIDTH  (16),
        .RESET_VALUE (32'h0),
        .ACK_TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ack    (out_ack)
`ifdef NIOS_NUMBERS_OUT_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        step();
        chipselect = 1'b0; write_n = 1'b1;
        $display("write addr=%0d data=0x%0h", a, d);
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        step();
        chipselect = 1'b0;
        $display("read addr=%0d data=0x%0h", a, readdata);
    endtask

    // Handshake monitor: valid&ack here means the transfer completes next edge.
    always @(negedge clk) begin
        if (!reset && out_valid === 1'b1 && out_ack === 1'b1) begin
            if (sb.size() == 0) begin
                check("xfer_unexpected", 32'(out_data), 32'hDEAD_BEEF);
            end else begin
                logic [15:0] e;
                e = sb.pop_front();
                $display("transfer data=0x%0h expected=0x%0h", out_data, e);
                check("xfer_data", 32'(out_data), 32'(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'd0; out_ack = 1'b0;
        step(); step();
        reset = 1'b0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
`ifdef NIOS_NUMBERS_OUT_IRQ_EN
        check("rst_irq", 32'(irq), 32'd0);
`endif
        bus_read(2'd0);
        check("rst_rd_data", readdata, 32'h0);
        bus_read(2'd1);
        check("rst_rd_status", readdata, 32'h0);

        // Basic transfer with a delayed ack
        sb.push_back(16'h1234);
        bus_write(2'd0, 32'h1234);
        check("pres_valid", 32'(out_valid), 32'd1);
        check("pres_data", 32'(out_data), 32'h1234);
        bus_read(2'd1);
        check("busy_status", readdata, 32'h1);
        bus_read(2'd0);
        check("data_readback", readdata, 32'h1234);
        step(); step(); step();
        check("still_valid", 32'(out_valid), 32'd1);
        out_ack = 1'b1; step(); out_ack = 1'b0;
        check("ack_done_valid", 32'(out_valid), 32'd0);

        // Overflow: write while pending without ack is dropped
        sb.push_back(16'hAAAA);
        bus_write(2'd0, 32'hAAAA);
        bus_write(2'd0, 32'h5555);
        check("ovf_data_kept", 32'(out_data), 32'hAAAA);
        check("ovf_valid", 32'(out_valid), 32'd1);
        bus_read(2'd1);
        check("ovf_status", readdata, 32'h3 | DN);
        bus_write(2'd1, 32'h2);
        bus_read(2'd1);
        check("ovf_cleared", readdata, 32'h1 | DN);
        out_ack = 1'b1; step(); out_ack = 1'b0;
        check("ovf_ack_valid", 32'(out_valid), 32'd0);

        // Write coinciding with ack replaces the value without overflow
        sb.push_back(16'h0041);
        bus_write(2'd0, 32'h0041);
        sb.push_back(16'h0042);
        out_ack = 1'b1;
        bus_write(2'd0, 32'h0042);
        out_ack = 1'b0;
        check("same_valid", 32'(out_valid), 32'd1);
        check("same_data", 32'(out_data), 32'h0042);
        bus_read(2'd1);
        check("same_status", readdata, 32'h1 | DN);
        out_ack = 1'b1; step(); out_ack = 1'b0;
        check("same_ack_valid", 32'(out_valid), 32'd0);

        // Timeout after exactly 8 cycles with no ack
        bus_write(2'd0, 32'h00FF);
        check("to_valid", 32'(out_valid), 32'd1);
        n = 0;
        while (out_valid === 1'b1 && n < 20) begin
            step();
            n++;
        end
        $display("timeout after %0d cycles", n);
        check("to_cycles", 32'(n), 32'd8);
        bus_read(2'd1);
        check("to_status", readdata, 32'h4 | DN);
        out_ack = 1'b1; step(); out_ack = 1'b0;
        check("idle_ack_ignored", 32'(out_valid), 32'd0);
        bus_read(2'd0);
        check("to_data_kept", readdata, 32'h00FF);
        bus_write(2'd1, 32'h4);
        bus_read(2'd1);
        check("to_cleared", readdata, DN);

        // CONTROL / unused address / interrupt path
        bus_write(2'd1, 32'h8);
        bus_write(2'd3, 32'hFFFF);
        bus_read(2'd3);
        check("addr3_read", readdata, 32'h0);
        bus_write(2'd2, 32'h1);
        bus_read(2'd2);
        check("ctrl_read", readdata, CTRL_RB);
`ifdef NIOS_NUMBERS_OUT_IRQ_EN
        check("irq_idle", 32'(irq), 32'd0);
`endif
        sb.push_back(16'h0077);
        bus_write(2'd0, 32'h0077);
        out_ack = 1'b1; step(); out_ack = 1'b0;
`ifdef NIOS_NUMBERS_OUT_IRQ_EN
        check("irq_done", 32'(irq), 32'd1);
`endif
        bus_read(2'd1);
        check("done_status", readdata, DN);
        bus_write(2'd1, 32'h8);
`ifdef NIOS_NUMBERS_OUT_IRQ_EN
        check("irq_cleared", 32'(irq), 32'd0);
`endif

        // Reset while a value is pending drops it
        bus_write(2'd0, 32'h0099);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        reset = 1'b1; step(); reset = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
`ifdef NIOS_NUMBERS_OUT_IRQ_EN
        check("mid_rst_irq", 32'(irq), 32'd0);
`endif
        bus_read(2'd1);
        check("post_rst_status", readdata, 32'h0);
        bus_read(2'd2);
        check("post_rst_ctrl", readdata, 32'h0);

        step();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
